// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data-memory responder: responder FSM states,
// default geometry/latency constants and the request address check.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

   // Default number of 32-bit words and default wait cycles.
   localparam int unsigned DEFAULT_DEPTH = 32'd32;
   localparam int unsigned DEFAULT_WAIT  = 32'd2;

   // Width of the wait counter (WAIT is limited to 0..15).
   localparam int unsigned CNT_W = 32'd4;

   // Responder FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmr_state_e;

   // A request is bad when the byte address is not word aligned or falls at
   // or beyond the end of the array (limit = 4*DEPTH).
   function automatic logic addr_bad(input logic [31:0] addr,
                                     input logic [31:0] limit);
      addr_bad = (addr[1:0] != 2'b00) || (addr >= limit);
   endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
// Single-port word storage: synchronous write, combinational read. Contents
// are deliberately not reset.
// Ports:
//   clk_i    - clock
//   we_i     - write enable (write happens on the rising edge)
//   addr_i   - word index, shared by read and write
//   wdata_i  - write data
//   rdata_o  - combinational read data at addr_i
// -----------------------------------------------------------------------------
module mem_word_array #(
   parameter int unsigned DEPTH = 32'd32,
   parameter int unsigned AW    = 32'd5
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Synchronous write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Fixed-latency data-memory responder for a pipeline MEM stage. A request is
// accepted in IDLE, held for WAIT cycles, and completed in a single RESP cycle
// (ready high) exactly WAIT+1 cycles after the accept edge.
// Ports:
//   clk     - clock, all state on the rising edge
//   rst     - synchronous active-high reset (array contents are kept)
//   cs      - request valid
//   we      - 1 = write, 0 = read (sampled with cs)
//   addr_i  - byte address
//   data_i  - write data
//   data_o  - read data, held until the next read completes
//   ready   - response completes this cycle
//   stall   - cs AND NOT ready, holds the pipeline latches
//   err     - completing request was misaligned or out of range
// -----------------------------------------------------------------------------
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned WAIT  = DEFAULT_WAIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam int unsigned      AW         = $clog2(DEPTH);
   localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT);

   dmr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;

   logic [31:0]      sel_addr_s;
   logic             sel_we_s;
   logic             bad_s;
   logic             mem_we_s;
   logic [31:0]      mem_rdata_s;

   // With WAIT=0 the response is prepared on the accept edge itself, before
   // the request copy is registered, so the live inputs are used in IDLE.
   assign sel_addr_s = (state_q == ST_IDLE) ? addr_i : addr_q;
   assign sel_we_s   = (state_q == ST_IDLE) ? we     : we_q;
   assign bad_s      = addr_bad(sel_addr_s, ADDR_LIMIT);

   // Commit on the RESP edge; a reset in RESP drops the write.
   assign mem_we_s = (state_q == ST_RESP) && we_q && !bad_s && !rst;

   mem_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we_s),
      .addr_i  (sel_addr_s[AW+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata_s)
   );

   // Next-state, wait counter and request capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (cs) begin
               we_d    = we;
               addr_d  = addr_i;
               wdata_d = data_i;
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT == 32'd0) ? ST_RESP : ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Leaving at count 1 keeps the WAIT state exactly WAIT cycles long.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Response outputs are loaded on the edge that enters RESP so they are
   // registered and valid for the whole RESP cycle.
   always_comb begin
      ready_d = (state_d == ST_RESP);
      err_d   = ready_d && bad_s;
      rdata_d = rdata_q;
      if (ready_d) begin
         if (bad_s) begin
            rdata_d = 32'd0;
         end else if (!sel_we_s) begin
            rdata_d = mem_rdata_s;
         end else begin
            rdata_d = rdata_q;
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign data_o = rdata_q;
   assign ready  = ready_q;
   assign err    = err_q;
   assign stall  = cs && !ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders (index 0: WAIT=0, index 1: WAIT=2, both DEPTH=32) driven by
// directed and random transactions and compared against a word-array model.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int DEPTH = 32;

   logic        clk;
   logic        rst_v   [2];
   logic        cs_v    [2];
   logic        we_v    [2];
   logic [31:0] addr_v  [2];
   logic [31:0] wdata_v [2];
   logic [31:0] rdata_v [2];
   logic        ready_v [2];
   logic        stall_v [2];
   logic        err_v   [2];

   int          n_checks;
   int          n_fail;
   int          cyc;

   logic [31:0] mem_m    [2][DEPTH];
   logic [31:0] last_exp [2];
   int          last_rdy_cyc [2];

   data_mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .cs(cs_v[0]), .we(we_v[0]),
      .addr_i(addr_v[0]), .data_i(wdata_v[0]), .data_o(rdata_v[0]),
      .ready(ready_v[0]), .stall(stall_v[0]), .err(err_v[0])
   );

   data_mem_responder #(.DEPTH(DEPTH), .WAIT(2)) dut1 (
      .clk(clk), .rst(rst_v[1]), .cs(cs_v[1]), .we(we_v[1]),
      .addr_i(addr_v[1]), .data_i(wdata_v[1]), .data_o(rdata_v[1]),
      .ready(ready_v[1]), .stall(stall_v[1]), .err(err_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   // One full transaction: accept, WAIT cycles with scrambled inputs, RESP.
   task automatic do_txn(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
      int wt;
      bit bad;
      int idx;
      wt  = wait_of(k);
      bad = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
      idx = int'(a[6:2]);
      @(negedge clk);
      cs_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
      #1;
      check_eq("accept_stall", 32'(stall_v[k]), 32'd1);
      check_eq("accept_ready", 32'(ready_v[k]), 32'd0);
      for (int c = 1; c <= wt; c++) begin
         @(negedge clk);
         we_v[k] = 1'($urandom); addr_v[k] = $urandom; wdata_v[k] = $urandom;
         #1;
         check_eq("wait_ready", 32'(ready_v[k]), 32'd0);
         check_eq("wait_stall", 32'(stall_v[k]), 32'd1);
         check_eq("wait_data_hold", rdata_v[k], last_exp[k]);
      end
      @(negedge clk);
      we_v[k] = 1'($urandom); addr_v[k] = $urandom; wdata_v[k] = $urandom;
      #1;
      if (bad) last_exp[k] = 32'd0;
      else if (!w) last_exp[k] = mem_m[k][idx];
      check_eq("resp_ready", 32'(ready_v[k]), 32'd1);
      check_eq("resp_stall", 32'(stall_v[k]), 32'd0);
      check_eq("resp_err", 32'(err_v[k]), 32'(bad));
      check_eq("resp_data", rdata_v[k], last_exp[k]);
      last_rdy_cyc[k] = cyc;
      if (!bad && w) mem_m[k][idx] = d;
   endtask

   // One IDLE cycle with cs low.
   task automatic idle_cycle(input int k);
      @(negedge clk);
      cs_v[k] = 1'b0; addr_v[k] = $urandom; wdata_v[k] = $urandom;
      #1;
      check_eq("idle_ready", 32'(ready_v[k]), 32'd0);
      check_eq("idle_stall", 32'(stall_v[k]), 32'd0);
      check_eq("idle_err", 32'(err_v[k]), 32'd0);
      check_eq("idle_data_hold", rdata_v[k], last_exp[k]);
   endtask

   // Start a write and reset on the cycle after accept; the write must be lost.
   task automatic reset_mid(input int k, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cs_v[k] = 1'b1; we_v[k] = 1'b1; addr_v[k] = a; wdata_v[k] = d;
      @(negedge clk);
      rst_v[k] = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rst_ready", 32'(ready_v[k]), 32'd0);
      check_eq("rst_err", 32'(err_v[k]), 32'd0);
      check_eq("rst_data", rdata_v[k], 32'd0);
      check_eq("rst_stall_cs", 32'(stall_v[k]), 32'd1);
      rst_v[k] = 1'b0; cs_v[k] = 1'b0;
      #1;
      check_eq("rst_stall_idle", 32'(stall_v[k]), 32'd0);
      last_exp[k] = 32'd0;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return {25'd0, 5'($urandom), 2'($urandom_range(1, 3))};
      if (r == 1) return 32'd128 + 32'($urandom_range(0, 4000)) * 32'd4 + 32'($urandom_range(0, 3));
      return {25'd0, 5'($urandom), 2'b00};
   endfunction

   initial begin
      int c1;
      n_checks = 0; n_fail = 0; cyc = 0;
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1; cs_v[k] = 1'b0; we_v[k] = 1'b0;
         addr_v[k] = 32'd0; wdata_v[k] = 32'd0;
         last_exp[k] = 32'd0; last_rdy_cyc[k] = 0;
      end
      repeat (3) @(negedge clk);
      // Reset state.
      for (int k = 0; k < 2; k++) begin
         check_eq("reset_ready", 32'(ready_v[k]), 32'd0);
         check_eq("reset_err", 32'(err_v[k]), 32'd0);
         check_eq("reset_data", rdata_v[k], 32'd0);
         check_eq("reset_stall", 32'(stall_v[k]), 32'd0);
         rst_v[k] = 1'b0;
      end

      for (int k = 0; k < 2; k++) begin
         // Give every word a known value.
         for (int i = 0; i < DEPTH; i++) do_txn(k, 1'b1, 32'(i * 4), $urandom);
         idle_cycle(k);

         // Write then read back the same word.
         do_txn(k, 1'b1, 32'h8, 32'hDEADBEEF);
         idle_cycle(k);
         do_txn(k, 1'b0, 32'h8, 32'h0);
         do_txn(k, 1'b1, 32'h0, 32'h12345678);
         do_txn(k, 1'b0, 32'h0, 32'h0);
         idle_cycle(k);

         // Misaligned and out-of-range reads, then neighbouring word intact.
         do_txn(k, 1'b0, 32'h6, 32'h0);
         idle_cycle(k);
         do_txn(k, 1'b0, 32'h80, 32'h0);
         idle_cycle(k);
         do_txn(k, 1'b1, 32'h5, 32'hFFFFFFFF);
         do_txn(k, 1'b0, 32'h4, 32'h0);

         // Aborted write followed by a read of the same word.
         reset_mid(k, 32'h4, 32'h1);
         do_txn(k, 1'b0, 32'h4, 32'h0);
         idle_cycle(k);

         // Back-to-back reads with cs held high.
         do_txn(k, 1'b0, 32'h0, 32'h0);
         c1 = last_rdy_cyc[k];
         do_txn(k, 1'b0, 32'h4, 32'h0);
         check_eq("b2b_gap", 32'(last_rdy_cyc[k] - c1), 32'(wait_of(k) + 2));
         idle_cycle(k);

         // Random traffic.
         for (int n = 0; n < 200; n++) begin
            do_txn(k, 1'($urandom), rand_addr(), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle(k);
         end
         idle_cycle(k);

         // Read back the whole array.
         for (int i = 0; i < DEPTH; i++) do_txn(k, 1'b0, 32'(i * 4), 32'h0);
         idle_cycle(k);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT, default 2, meaning the wait cycles between request accept and response (0..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cs, input, 1 bit: request valid from the pipeline MEM stage.
REQ-007 SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with cs.
REQ-008 SHALL have port addr_i, input, 32 bits: byte address.
REQ-009 SHALL have port data_i, input, 32 bits: write data.
REQ-010 SHALL have port data_o, output, 32 bits: read data.
REQ-011 SHALL have port ready, output, 1 bit: response complete this cycle.
REQ-012 SHALL have port stall, output, 1 bit: asks the pipeline to hold its latches.
REQ-013 SHALL have port err, output, 1 bit: the completing request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with cs=1, SHALL register we, addr_i and data_i, load the wait counter with WAIT, and go to WAIT; if WAIT=0, go directly to RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP when it reaches 1.
REQ-017 SHALL give fixed latency: ready rises exactly WAIT+1 cycles after the accept edge.
REQ-018 SHALL ignore cs, we, addr_i and data_i in WAIT and RESP; only the registered copy is used.
REQ-019 In RESP, SHALL assert ready for exactly one cycle, then return to IDLE; a cs seen in RESP is not accepted.
REQ-020 SHALL treat cs held high in the IDLE cycle after RESP as a new request, accepted back-to-back.
REQ-021 SHALL drive stall = cs AND NOT ready (combinational), and stall=0 in IDLE when cs=0.
REQ-022 SHALL form the word index from addr[log2(DEPTH)+1:2].
REQ-023 SHALL flag a request as bad when addr[1:0]≠0 or addr ≥ 4*DEPTH.
REQ-024 For a good write, SHALL write the array on the RESP edge; data_o is unchanged.
REQ-025 For a good read, SHALL drive data_o with the array word during RESP and hold that value until the next read RESP.
REQ-026 For a bad request, SHALL assert err with ready for the RESP cycle only, drive data_o=0, and leave the array unmodified.
REQ-027 SHALL make a write in RESP followed by a read of the same word return the new value.

Reset
REQ-028 On rst=1 at a clock edge, SHALL go to state IDLE, clear the counter, and set data_o=0, ready=0, err=0.
REQ-029 On reset mid-operation (WAIT or RESP), SHALL abort the pending request; a pending write is not committed.
REQ-030 SHALL not clear array contents on reset.
REQ-031 SHALL have rst take priority over cs in the same cycle.

Structure
REQ-032 SHALL place the FSM state enum (IDLE/WAIT/RESP) and the default DEPTH/WAIT constants in the shared CPU package.
REQ-033 SHALL place word storage in one sub-module, mem_word_array (single-port, synchronous write, combinational read).
REQ-034 SHALL implement the FSM, counter and address check in data_mem_responder.

Verification
REQ-035 Write 0xDEADBEEF to addr 0x8 with WAIT=2 -> ready high at accept+3 cycles, stall=1 for cycles 0..2; then read 0x8 -> data_o=0xDEADBEEF at RESP.
REQ-036 WAIT=0, read addr 0x0 after writing 0x12345678 -> ready one cycle after accept, data_o=0x12345678.
REQ-037 Read addr 0x6 (misaligned), then addr 0x80 with DEPTH=32 -> err=1, data_o=0 at each RESP; a later read of word 1 shows it unchanged.
REQ-038 Write 0x1 to 0x4 and assert rst in the WAIT cycle -> state IDLE, ready=0; a read of 0x4 returns the prior value.
REQ-039 Hold cs=1 across two back-to-back reads (0x0, 0x4) with addr changed after the first ready -> two ready pulses WAIT+2 cycles apart with the correct data each.
REQ-040 Change addr_i and data_i during WAIT -> the originally captured address and data are used.
